aes_128_decrypt_iter: RTL and testbench

- Iterative, handshaked AES-128 decryption core. It is the inverse-direction counterpart to the combinational AES_128_Encrypt datapath.
- Accepts a ciphertext block plus a cipher key and returns the plaintext over valid/ready interfaces.
- Key expansion runs on-chip; the last expanded key is cached so back-to-back blocks under the same key skip expansion.
- Sits beside the encrypt cores in the top level so encrypted streams can be round-tripped.

---
 rtl/aes_128_decrypt_iter.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_aes_128_decrypt_iter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryption core: on-chip key expansion into a one-entry
// round-key cache, then ten inverse rounds, behind valid/ready handshakes.

package aes_128_decrypt_iter_pkg;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NUM_RK = 11;

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (product a^2 * a^4 * ... * a^128); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] pw;
    logic [7:0] acc;
    pw  = gf_mul(a, a);
    acc = pw;
    for (int i = 2; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      acc = gf_mul(acc, pw);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c - row + 4) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    logic [7:0]       a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction
endpackage

// Forward S-box: field inverse followed by the affine map
module sbox
  import aes_128_decrypt_iter_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_c_o
);
  logic [7:0] inv_c;
  assign inv_c    = gf_inv(data_i);
  assign data_c_o = inv_c ^ {inv_c[6:0], inv_c[7]} ^ {inv_c[5:0], inv_c[7:6]}
                  ^ {inv_c[4:0], inv_c[7:5]} ^ {inv_c[3:0], inv_c[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine map followed by the field inverse
module inv_sbox
  import aes_128_decrypt_iter_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_c_o
);
  logic [7:0] pre_c;
  assign pre_c    = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]}
                  ^ {data_i[1:0], data_i[7:2]} ^ 8'h05;
  assign data_c_o = gf_inv(pre_c);
endmodule

module aes_128_decrypt_iter
  import aes_128_decrypt_iter_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [BLK_W-1:0] ciphertext_i,
  input  logic [BLK_W-1:0] cipher_key_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BLK_W-1:0] plaintext_o,
  output logic             busy_o,
  output logic             cache_hit_o
);
  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_KEYEXP = 2'd1;
  localparam logic [1:0]       S_DEC    = 2'd2;
  localparam logic [1:0]       S_DONE   = 2'd3;
  localparam logic [CNT_W-1:0] LAST_RK  = CNT_W'(NUM_RK - 1);
  localparam logic [CNT_W-1:0] FIRST_RD = CNT_W'(NUM_RK - 2);

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_RK-1:0][BLK_W-1:0] rk_q;
  logic [BLK_W-1:0]             ct_q, ct_d;
  logic [BLK_W-1:0]             blk_q, blk_d;
  logic [BLK_W-1:0]             pt_q, pt_d;
  logic                         cache_valid_q, cache_valid_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         busy_q, busy_d;
  logic                         hit_q, hit_d;

  logic                         rk_wr_c;
  logic [CNT_W-1:0]             rk_wr_idx_c;
  logic [BLK_W-1:0]             rk_wr_data_c;
  logic                         hit_c;
  logic [CNT_W-1:0]             rk_prev_idx_c;
  logic [BLK_W-1:0]             rk_prev_c;
  logic [31:0]                  rot_c, sub_word_c, temp_c;
  logic [31:0]                  n0_c, n1_c, n2_c, n3_c;
  logic [BLK_W-1:0]             rk_next_c;
  logic [BLK_W-1:0]             isr_c, isb_c, ark_c, round_c;

  assign hit_c = KEY_CACHE && cache_valid_q && (cipher_key_i == rk_q[0]);

  // Key schedule step: rk[cnt] from rk[cnt-1]
  assign rk_prev_idx_c = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
  assign rk_prev_c     = rk_q[rk_prev_idx_c];
  assign rot_c         = {rk_prev_c[23:0], rk_prev_c[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_ksbox
    sbox u_sbox (
      .data_i   (rot_c[8*g +: 8]),
      .data_c_o (sub_word_c[8*g +: 8])
    );
  end

  assign temp_c    = sub_word_c ^ {rcon(cnt_q), 24'h000000};
  assign n0_c      = rk_prev_c[127:96] ^ temp_c;
  assign n1_c      = rk_prev_c[95:64]  ^ n0_c;
  assign n2_c      = rk_prev_c[63:32]  ^ n1_c;
  assign n3_c      = rk_prev_c[31:0]   ^ n2_c;
  assign rk_next_c = {n0_c, n1_c, n2_c, n3_c};

  // Inverse round r = cnt_q; the final round (r=0) skips InvMixColumns
  assign isr_c = inv_shift_rows(blk_q);

  for (genvar g = 0; g < 16; g++) begin : g_rsbox
    inv_sbox u_inv_sbox (
      .data_i   (isr_c[8*g +: 8]),
      .data_c_o (isb_c[8*g +: 8])
    );
  end

  assign ark_c   = isb_c ^ rk_q[cnt_q];
  assign round_c = (cnt_q == '0) ? ark_c : inv_mix_columns(ark_c);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ct_d          = ct_q;
    blk_d         = blk_q;
    pt_d          = pt_q;
    cache_valid_d = cache_valid_q;
    hit_d         = 1'b0;
    rk_wr_c       = 1'b0;
    rk_wr_idx_c   = '0;
    rk_wr_data_c  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          ct_d = ciphertext_i;
          if (hit_c) begin
            blk_d   = ciphertext_i ^ rk_q[LAST_RK];
            cnt_d   = FIRST_RD;
            hit_d   = 1'b1;
            state_d = S_DEC;
          end else begin
            rk_wr_c       = 1'b1;
            rk_wr_data_c  = cipher_key_i;
            cnt_d         = CNT_W'(1);
            cache_valid_d = 1'b0;
            state_d       = S_KEYEXP;
          end
        end
      end
      S_KEYEXP: begin
        rk_wr_c      = 1'b1;
        rk_wr_idx_c  = cnt_q;
        rk_wr_data_c = rk_next_c;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_RK) begin
          blk_d         = ct_q ^ rk_next_c;
          cache_valid_d = 1'b1;
          cnt_d         = FIRST_RD;
          state_d       = S_DEC;
        end
      end
      S_DEC: begin
        blk_d = round_c;
        if (cnt_q == '0) begin
          pt_d    = round_c;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_KEYEXP) || (state_d == S_DEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rk_q          <= '0;
      ct_q          <= '0;
      blk_q         <= '0;
      pt_q          <= '0;
      cache_valid_q <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ct_q          <= ct_d;
      blk_q         <= blk_d;
      pt_q          <= pt_d;
      cache_valid_q <= cache_valid_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      hit_q         <= hit_d;
      if (rk_wr_c) rk_q[rk_wr_idx_c] <= rk_wr_data_c;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign plaintext_o = pt_q;
  assign busy_o      = busy_q;
  assign cache_hit_o = hit_q;
endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// Bench for aes_128_decrypt_iter: FIPS-197 vectors plus random blocks against a
// byte-array AES model, on a cached (u_dut0) and a non-cached (u_dut1) build.
module tb_aes_128_decrypt_iter;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid, in_ready, out_valid, out_ready, busy, hit;
  logic [127:0] ct_in [2];
  logic [127:0] key_in [2];
  logic [127:0] pt0, pt1;

  int           n_cmp = 0;
  int           n_bad = 0;
  bit           cache_ok [2];
  logic [127:0] cache_key [2];
  logic [7:0]   sb_t [256];
  logic [7:0]   isb_t [256];

  always #5 clk = ~clk;

  aes_128_decrypt_iter #(.KEY_CACHE(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .ciphertext_i(ct_in[0]), .cipher_key_i(key_in[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .plaintext_o(pt0), .busy_o(busy[0]), .cache_hit_o(hit[0])
  );

  aes_128_decrypt_iter #(.KEY_CACHE(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .ciphertext_i(ct_in[1]), .cipher_key_i(key_in[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .plaintext_o(pt1), .busy_o(busy[1]), .cache_hit_o(hit[1])
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Polynomial product then long division by 0x11b
  function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (poly_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb_t[x] = s;
    end
    for (int x = 0; x < 256; x++) isb_t[sb_t[x]] = 8'(x);
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [7:0]   w [44][4];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   col [4];
    logic [7:0]   m [4];
    logic [7:0]   rc, first;
    logic [127:0] res;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[127 - 8*(4*i + j) -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        first  = tmp[0];
        tmp[0] = sb_t[tmp[1]] ^ rc;
        tmp[1] = sb_t[tmp[2]];
        tmp[2] = sb_t[tmp[3]];
        tmp[3] = sb_t[first];
        rc     = poly_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int k = 0; k < 16; k++) s[k] = ct[127 - 8*k -: 8] ^ w[40 + k/4][k%4];
    for (int r = 9; r >= 0; r--) begin
      // row rw was rotated left by rw on encryption; rotate it back right
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[rw + 4*((c + rw) % 4)] = s[rw + 4*c];
      for (int k = 0; k < 16; k++) s[k] = isb_t[t[k]] ^ w[4*r + k/4][k%4];
      if (r != 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) begin
            col[i] = 8'h00;
            for (int j = 0; j < 4; j++) col[i] = col[i] ^ poly_mul(m[(j - i + 4) % 4], s[4*c + j]);
          end
          for (int i = 0; i < 4; i++) s[4*c + i] = col[i];
        end
      end
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] pt_of(input int d);
    return (d == 0) ? pt0 : pt1;
  endfunction

  // One full transaction: offer, accept, optional input noise, optional backpressure, drain
  task automatic run_block(input int d, input logic [127:0] c, input logic [127:0] k,
                           input logic [127:0] exp_pt, input int hold, input bit garbage,
                           input bit eager);
    bit           exp_hit;
    int           lat, w;
    logic [127:0] pt_seen;
    exp_hit = (d == 0) && cache_ok[d] && (k == cache_key[d]);
    @(negedge clk);
    in_valid[d] = 1'b1;
    ct_in[d]    = c;
    key_in[d]   = k;
    out_ready[d] = eager;
    w = 0;
    while (!in_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      check_eq($sformatf("d%0d_accept_timeout", d), 128'(w), 128'(0));
      in_valid[d] = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid[d] = garbage;
    check_eq($sformatf("d%0d_cache_hit", d), 128'(hit[d]), 128'(exp_hit));
    check_eq($sformatf("d%0d_busy_run", d), 128'(busy[d]), 128'(1));
    check_eq($sformatf("d%0d_in_ready_run", d), 128'(in_ready[d]), 128'(0));
    cache_ok[d]  = 1'b1;
    cache_key[d] = k;
    lat = 0;
    while (!out_valid[d] && lat < 40) begin
      if (garbage) begin
        ct_in[d]  = rand128();
        key_in[d] = rand128();
      end
      @(negedge clk);
      lat++;
    end
    in_valid[d] = 1'b0;
    check_eq($sformatf("d%0d_latency", d), 128'(lat), exp_hit ? 128'(10) : 128'(20));
    check_eq($sformatf("d%0d_plaintext", d), pt_of(d), exp_pt);
    check_eq($sformatf("d%0d_in_ready_done", d), 128'(in_ready[d]), 128'(0));
    check_eq($sformatf("d%0d_busy_done", d), 128'(busy[d]), 128'(0));
    pt_seen = pt_of(d);
    if (!eager) begin
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
        check_eq($sformatf("d%0d_hold_valid", d), 128'(out_valid[d]), 128'(1));
        check_eq($sformatf("d%0d_hold_pt", d), pt_of(d), pt_seen);
        check_eq($sformatf("d%0d_hold_in_ready", d), 128'(in_ready[d]), 128'(0));
      end
      out_ready[d] = 1'b1;
    end
    @(negedge clk);
    out_ready[d] = 1'b0;
    check_eq($sformatf("d%0d_drain_valid", d), 128'(out_valid[d]), 128'(0));
    check_eq($sformatf("d%0d_drain_in_ready", d), 128'(in_ready[d]), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] k, c;
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < 2; d++) begin
      ct_in[d]     = '0;
      key_in[d]    = '0;
      cache_ok[d]  = 1'b0;
      cache_key[d] = '0;
    end
    rst_n = 1'b1;
    build_tables();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 128'(in_ready[0]), 128'(1));
    check_eq("rst_out_valid", 128'(out_valid[0]), 128'(0));
    check_eq("rst_plaintext", pt0, 128'(0));
    check_eq("rst_busy", 128'(busy[0]), 128'(0));
    check_eq("rst_cache_hit", 128'(hit[0]), 128'(0));
    rst_n = 1'b1;

    // FIPS-197 vectors: miss, miss on new key, hit with backpressure, hit under noise
    run_block(0, C1_CT, C1_KEY, C1_PT, 0, 1'b0, 1'b0);
    run_block(0, B_CT, B_KEY, B_PT, 0, 1'b0, 1'b0);
    run_block(0, B_CT, B_KEY, B_PT, 15, 1'b0, 1'b0);
    run_block(0, C1_CT, C1_KEY, C1_PT, 0, 1'b1, 1'b0);
    run_block(0, C1_CT, C1_KEY, C1_PT, 2, 1'b1, 1'b1);

    // Reset mid-DEC on a cache-hit block
    @(negedge clk);
    in_valid[0] = 1'b1;
    ct_in[0]    = C1_CT;
    key_in[0]   = C1_KEY;
    check_eq("mid_rst_ready", 128'(in_ready[0]), 128'(1));
    @(negedge clk);
    in_valid[0] = 1'b0;
    check_eq("mid_rst_hit", 128'(hit[0]), 128'(1));
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 128'(busy[0]), 128'(0));
    check_eq("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    check_eq("mid_rst_plaintext", pt0, 128'(0));
    check_eq("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    cache_ok[0] = 1'b0;
    cache_ok[1] = 1'b0;
    run_block(0, C1_CT, C1_KEY, C1_PT, 0, 1'b0, 1'b0);

    // Random blocks, about half reusing the previous key
    k = rand128();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(1, 0) == 0) k = rand128();
      c = rand128();
      run_block(0, c, k, ref_decrypt(c, k), int'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // Non-caching build: repeated key must always expand
    run_block(1, C1_CT, C1_KEY, C1_PT, 0, 1'b0, 1'b0);
    run_block(1, C1_CT, C1_KEY, C1_PT, 0, 1'b0, 1'b1);
    run_block(1, C1_CT, C1_KEY, C1_PT, 3, 1'b1, 1'b0);
    k = rand128();
    for (int i = 0; i < 3; i++) begin
      c = rand128();
      run_block(1, c, k, ref_decrypt(c, k), 1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
